maxterm_sweep_engine: RTL

Parametrised, sequential truth-table generator for product-of-maxterms functions.
- Latches N_FUNC maxterm masks over N_IN inputs.
- Steps an input counter through all 2^N_IN combinations.
- Streams one row per accepted beat over a valid/ready handshake.
- Replaces fixed 3-input combinational maxterm expressions plus a free-running testbench sweep with a reusable, flow-controlled hardware block for the Guia exercise framework.

---
 rtl/maxterm_sweep_engine_if.sv | 41 ++++
 rtl/maxterm_sweep_engine.sv | 122 ++++++++++++
 2 files changed

// File: rtl/maxterm_sweep_engine_if.sv
// Handshake and data bundle for maxterm_sweep_engine.
// The master side requests sweeps and consumes rows; the slave side is the engine.
// Optional MINTERM_MODE_EN adds the mode_min select line.
interface maxterm_sweep_engine_if #(
  parameter int N_IN   = 3,
  parameter int N_FUNC = 5,
  parameter int CNT_W  = 8
);
  localparam int R = 1 << N_IN;

  logic                  start;
  logic                  abort;
  logic [N_FUNC*R-1:0]   mask;
`ifdef MINTERM_MODE_EN
  logic                  mode_min;
`endif
  logic                  out_ready;
  logic                  out_valid;
  logic [N_IN-1:0]       out_idx;
  logic [N_FUNC-1:0]     out_bits;
  logic                  out_last;
  logic                  busy;
  logic                  done;
  logic [CNT_W-1:0]      sweep_cnt;

  modport master (
`ifdef MINTERM_MODE_EN
    output mode_min,
`endif
    output start, abort, mask, out_ready,
    input  out_valid, out_idx, out_bits, out_last, busy, done, sweep_cnt
  );

  modport slave (
`ifdef MINTERM_MODE_EN
    input  mode_min,
`endif
    input  start, abort, mask, out_ready,
    output out_valid, out_idx, out_bits, out_last, busy, done, sweep_cnt
  );
endinterface

// File: rtl/maxterm_sweep_engine.sv
// Sequential truth-table generator for N_FUNC product-of-maxterms functions.
// On start the masks are latched and every input combination 0..2^N_IN-1 is
// streamed as one row per accepted valid/ready beat, then a one-cycle done
// pulse bumps a saturating completed-sweep counter.
// Optional macro MINTERM_MODE_EN adds a mode_min input selecting minterm
// (non-inverted) interpretation of the masks, latched together with them.
module maxterm_sweep_engine #(
  parameter int N_IN   = 3,
  parameter int N_FUNC = 5,
  parameter int CNT_W  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  maxterm_sweep_engine_if.slave bus
);
  localparam int R     = 1 << N_IN;
  localparam int IDX_W = N_IN + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_FUNC*R-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef MINTERM_MODE_EN
  logic                mode_q, mode_d;
`endif

  logic                sweeping;
  logic                is_last;
  logic                accept;
  logic [N_FUNC-1:0]   row_bits;

  assign sweeping = (state_q == SWEEP);
  assign is_last  = (idx_q == LAST_IDX);
  assign accept   = sweeping && bus.out_ready;

  // Pick each function's mask bit for the current row
  for (genvar f = 0; f < N_FUNC; f++) begin : g_func
    logic [R-1:0] fmask;
    assign fmask       = mask_q[f*R +: R];
    assign row_bits[f] = fmask[idx_q[N_IN-1:0]];
  end

  // State, row index, latched masks and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
`ifdef MINTERM_MODE_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
`ifdef MINTERM_MODE_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Next-state: abort beats start in IDLE and beats an accept in SWEEP
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
`ifdef MINTERM_MODE_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          mask_d  = bus.mask;
`ifdef MINTERM_MODE_EN
          mode_d  = bus.mode_min;
`endif
          idx_d   = '0;
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (accept) begin
          if (is_last) state_d = DONE;
          else         idx_d   = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Row outputs are forced to zero outside SWEEP so idle/reset read as all-zero
  always_comb begin
    bus.out_valid = sweeping;
    bus.busy      = sweeping;
    bus.done      = (state_q == DONE);
    bus.sweep_cnt = cnt_q;
    bus.out_idx   = '0;
    bus.out_bits  = '0;
    bus.out_last  = 1'b0;
    if (sweeping) begin
      bus.out_idx  = idx_q[N_IN-1:0];
      bus.out_last = is_last;
`ifdef MINTERM_MODE_EN
      bus.out_bits = mode_q ? row_bits : ~row_bits;
`else
      bus.out_bits = ~row_bits;
`endif
    end
  end
endmodule
